// File: rtl/spi_req_sched.sv
// spi_req_sched: shares one SPI controller between NUM_REQ requesters.
// Round-robin arbitration in IDLE, then programs the controller over its
// 8-bit APB port (address, data, control), polls control bit0 until the
// transfer completes and pulses done_o to the granted requester.
// Optional feature macro: SPI_SCHED_TIMEOUT_EN (poll limit, err_o pulse).
module spi_req_sched #(
    parameter int NUM_REQ  = 4,
    parameter int POLL_GAP = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic                   pclk_i,
    input  logic                   prst_n_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ*7-1:0]   req_addr_i,
    input  logic [NUM_REQ*8-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic [NUM_REQ-1:0]     err_o,
    output logic [7:0]             paddr_o,
    output logic [7:0]             pwdata_o,
    output logic                   pwrite_o,
    output logic                   penable_o,
    input  logic [7:0]             prdata_i,
    input  logic                   pready_i
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [7:0] ADDR_REG = 8'h00;
    localparam logic [7:0] DATA_REG = 8'h10;
    localparam logic [7:0] CTRL_REG = 8'h20;

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_CTRL, GAP, RD_CTRL, DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [IW:0]   cand;
    logic          found;
    logic [6:0]    sel_addr;
    logic [7:0]    sel_data;
    logic [7:0]    data_q;
    logic [GW-1:0] gap_cnt;
    logic          busy;

    // Only bit0 of the control register matters here.
    wire unused_prdata = ^prdata_i[7:1];

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int PCW = $clog2(TIMEOUT + 1);
    logic [PCW-1:0] poll_cnt;
`else
    // Parameter is only meaningful in the timeout build.
    localparam int unused_timeout = TIMEOUT;
    assign err_o = '0;
`endif

    // Round-robin pick: first requesting index after the last winner.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
            if (!found && req_i[cand[IW-1:0]]) begin
                found = 1'b1;
                win   = cand[IW-1:0];
            end
        end
    end

    // Payload of the current round-robin winner.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win == IW'(k)) begin
                sel_addr = req_addr_i[7*k +: 7];
                sel_data = req_wdata_i[8*k +: 8];
            end
        end
    end

    // Scheduler FSM; penable_o high marks an access phase, and a WR_*/RD_CTRL
    // state with penable_o low is that access's release cycle.
    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            state     <= IDLE;
            ptr       <= IW'(NUM_REQ - 1);
            data_q    <= '0;
            gap_cnt   <= '0;
            busy      <= 1'b0;
            gnt_o     <= '0;
            done_o    <= '0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
            pwrite_o  <= 1'b0;
            penable_o <= 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
            err_o     <= '0;
            poll_cnt  <= '0;
`endif
        end else begin
            done_o <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
            err_o  <= '0;
`endif
            if (penable_o) begin
                if (pready_i) begin
                    penable_o <= 1'b0;
                    pwrite_o  <= 1'b0;
                    paddr_o   <= '0;
                    pwdata_o  <= '0;
                    if (state == RD_CTRL) begin
                        busy <= prdata_i[0];
`ifdef SPI_SCHED_TIMEOUT_EN
                        poll_cnt <= poll_cnt + 1'b1;
`endif
                    end
                end
            end else begin
                case (state)
                    IDLE: if (found) begin
                        ptr       <= win;
                        gnt_o     <= NUM_REQ'(1) << win;
                        data_q    <= sel_data;
                        state     <= WR_ADDR;
                        paddr_o   <= ADDR_REG;
                        pwdata_o  <= {1'b1, sel_addr};
                        pwrite_o  <= 1'b1;
                        penable_o <= 1'b1;
`ifdef SPI_SCHED_TIMEOUT_EN
                        poll_cnt  <= '0;
`endif
                    end
                    WR_ADDR: begin
                        state     <= WR_DATA;
                        paddr_o   <= DATA_REG;
                        pwdata_o  <= data_q;
                        pwrite_o  <= 1'b1;
                        penable_o <= 1'b1;
                    end
                    WR_DATA: begin
                        state     <= WR_CTRL;
                        paddr_o   <= CTRL_REG;
                        pwdata_o  <= 8'h01;
                        pwrite_o  <= 1'b1;
                        penable_o <= 1'b1;
                    end
                    WR_CTRL: begin
                        state   <= GAP;
                        gap_cnt <= GW'(POLL_GAP - 1);
                    end
                    GAP: begin
                        if (gap_cnt == '0) begin
                            state     <= RD_CTRL;
                            paddr_o   <= CTRL_REG;
                            penable_o <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    RD_CTRL: begin
                        if (!busy) begin
                            state  <= DONE;
                            done_o <= gnt_o;
`ifdef SPI_SCHED_TIMEOUT_EN
                        end else if (poll_cnt == PCW'(TIMEOUT)) begin
                            state <= DONE;
                            err_o <= gnt_o;
`endif
                        end else begin
                            state   <= GAP;
                            gap_cnt <= GW'(POLL_GAP - 1);
                        end
                    end
                    DONE: begin
                        gnt_o <= '0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/spi_req_sched.md
# spi_req_sched

Request scheduler that shares one SPI controller between `NUM_REQ` requesters. It arbitrates round-robin and programs the controller over its 8-bit APB slave port by writing the address register, the data register and the control register. It then polls the control register until the transfer completes and returns a per-requester done pulse. It sits between the client blocks and the SPI controller's APB port and is the only APB master on that port.

## Interface
- `NUM_REQ`, 4: number of requesters, 1..8.
- `POLL_GAP`, 8: idle cycles between control-register polls, ≥1.
- `TIMEOUT`, 255: maximum polls per transfer (used only with `SPI_SCHED_TIMEOUT_EN`).

Ports:
- `pclk_i` in 1: single clock for the whole block.
- `prst_n_i` in 1: reset, asynchronous, active-low.
- `req_i` in NUM_REQ: request level per requester.
- `req_addr_i` in NUM_REQ*7: slave register address; requester k uses bits [7k+6:7k].
- `req_wdata_i` in NUM_REQ*8: write byte; requester k uses bits [8k+7:8k].
- `gnt_o` out NUM_REQ: one-hot grant, held for the whole transfer.
- `done_o` out NUM_REQ: one-cycle completion pulse to the granted requester.
- `err_o` out NUM_REQ: one-cycle timeout pulse (timeout build only; otherwise tied 0).
- `paddr_o` out 8: APB address.
- `pwdata_o` out 8: APB write data.
- `pwrite_o` out 1: APB write strobe.
- `penable_o` out 1: APB enable.
- `prdata_i` in 8: APB read data.
- `pready_i` in 1: APB ready.

## Operation
- Register map used: address register slot 0 is 0x00. Data register slot 0 is 0x10. The control register is 0x20, with bit0 = start/busy and bits[3:1] = transaction count − 1.
- Every transfer is exactly one SPI transaction:
  - Address byte = {1'b1, req_addr[6:0]}; MSB=1 marks a write.
  - Data byte = req_wdata.
  - Control byte = 8'h01.
- **Arbitration:**
  - Round-robin starting from the requester after the last granted one.
  - The pointer resets so requester 0 has highest priority first.
  - Arbitration happens only in IDLE.
  - The payload of the winner is latched at grant. Later changes to `req_i` and the payload are ignored until `done_o` or `err_o`.
- **States:**
  - IDLE → WR_ADDR when any `req_i` is high.
  - WR_ADDR → WR_DATA → WR_CTRL → GAP → RD_CTRL.
  - RD_CTRL → GAP if `prdata_i[0]`=1.
  - RD_CTRL → DONE if `prdata_i[0]`=0.
  - DONE → IDLE.
- **APB access phase (each WR_*/RD_CTRL state):**
  - Drive `paddr_o`, `pwdata_o`, `pwrite_o` and `penable_o`=1 until `pready_i` is sampled high.
  - Follow with one release cycle: `penable_o`=0, `pwrite_o`=0, `paddr_o`=0, `pwdata_o`=0.
  - `prdata_i` is sampled on the cycle `pready_i` is high.
- **Outputs by state:**
  - `gnt_o` is asserted from the first access cycle through the DONE cycle.
  - `done_o` is asserted in DONE only.
- **Simultaneous events:** a new request arriving in DONE is arbitrated in the following IDLE cycle. A requester that drops `req_i` mid-transfer still receives `done_o`.

## Timing
- **Reset values:** all outputs are 0, state is IDLE and the RR pointer is NUM_REQ−1. Reset is asynchronous and aborts any APB access mid-phase; `penable_o` drops immediately.
- **Latency with `pready_i` tied 1:**
  - `req_i` sampled at edge 0.
  - The address write is driven in cycle 1.
  - Each access takes 2 cycles: the access cycle plus the release cycle.
  - The first poll read occurs after 6 + `POLL_GAP` cycles.
  - `done_o` fires 2 cycles after the read that returns bit0=0.
- **Wait states:** each extra cycle with `pready_i`=0 extends the access by one cycle, and the signals are held stable.
- **Minimum turnaround:** at least one idle IDLE cycle separates consecutive transfers.

## Configuration
- `SPI_SCHED_TIMEOUT_EN` defined:
  - A poll counter counts RD_CTRL reads per transfer.
  - When it reaches `TIMEOUT` with bit0 still 1, the block pulses `err_o` for the granted requester instead of `done_o` and returns to IDLE.
  - The control register is not rewritten.
- `SPI_SCHED_TIMEOUT_EN` undefined:
  - The block polls indefinitely.
  - `err_o` is constant 0 and the counter is not synthesized.

## Test plan
- **Single request:** req 2 with addr 0x53, data 0x46, `pready_i`=1, and the first poll returning 0x00. Required APB writes: 0x00←0xD3, 0x10←0x46, 0x20←0x01. Then one read of 0x20, and `done_o`[2] pulses once.
- **Round-robin:** all four `req_i` held high. Required grant order 0,1,2,3,0, with no overlap of `gnt_o` bits.
- **Wait states and busy:** `pready_i` low for 3 cycles per access, and the control register reads 0x01 twice then 0x00. Required: signals stable during the waits, `POLL_GAP` idle cycles between reads, and exactly three reads.
- **Payload latched:** change `req_wdata_i` and drop `req_i` after grant. Required: the original data byte is written and `done_o` is still pulsed.
- **Reset mid-access:** assert `prst_n_i` during WR_DATA with `pready_i`=0. Required: `penable_o`=0 and `gnt_o`=0 asynchronously. After release, a pending req 0 is granted first.
- **Timeout (with `SPI_SCHED_TIMEOUT_EN`, `TIMEOUT`=4):** the control register always reads 0x01. Required: four reads, then `err_o` pulses, `done_o` stays 0, and the block returns to IDLE.
